// File: rtl/ram_wr_ctrl.sv
// Nibble-entry RAM writer: debounced keys build a staging word, a commit writes it to RAM.
// Registered read-back port and four hex 7-segment digit drivers.

module ram_wr_key_db #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic key_n_i,
    output logic pulse_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // any sample that agrees again restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
            prev_q <= stable_q;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(CYCLES - 1)) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pulse_o = ce & prev_q & ~stable_q;
endmodule

module ram_wr_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    localparam int NIB  = DATA_WIDTH / 4,
    localparam int CNTW = $clog2(NIB + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     key_load_n,
    input  logic                     key_commit_n,
    input  logic [3:0]               nibble_in,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     busy,
    output logic [CNTW-1:0]          entry_cnt,
    output logic [6:0]               D1,
    output logic [6:0]               D2,
    output logic [6:0]               D3,
    output logic [6:0]               D4
);
    localparam int PADW = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_WRITE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    staging_q, staging_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    dout_q;
    logic [DATA_WIDTH-1:0]    mem [0:(1 << ADDRESS_WIDTH)-1];
    logic                     load_p, commit_p;

    ram_wr_key_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst_n(rst_n), .ce(ce), .key_n_i(key_load_n), .pulse_o(load_p)
    );
    ram_wr_key_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
        .clk(clk), .rst_n(rst_n), .ce(ce), .key_n_i(key_commit_n), .pulse_o(commit_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            staging_q <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            dout_q    <= '0;
        end else if (ce) begin
            state_q   <= state_d;
            staging_q <= staging_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            dout_q    <= mem[address_in];
        end
    end

    // RAM is deliberately not reset; the read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ce && state_q == S_WRITE)
            mem[wr_addr_q] <= staging_q;
    end

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            S_IDLE: begin
                if (load_p) begin
                    staging_d = DATA_WIDTH'({staging_q, nibble_in});
                    cnt_d     = CNTW'(1);
                    state_d   = S_ENTER;
                end
            end
            S_ENTER: begin
                if (commit_p) begin
                    wr_addr_d = address_in;
                    state_d   = S_WRITE;
                end else if (load_p) begin
                    staging_d = DATA_WIDTH'({staging_q, nibble_in});
                    if (cnt_q != CNTW'(NIB))
                        cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_WRITE: begin
                state_d   = S_IDLE;
                staging_d = '0;
                cnt_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    logic [PADW-1:0] disp_pad;
    logic [15:0]     disp;

    // Narrow words are zero-extended; wide words show their top four nibbles.
    always_comb begin
        disp_pad = PADW'((state_q == S_ENTER) ? staging_q : dout_q);
        disp     = disp_pad[PADW-1 -: 16];
    end

    assign D1        = seg7(disp[15:12]);
    assign D2        = seg7(disp[11:8]);
    assign D3        = seg7(disp[7:4]);
    assign D4        = seg7(disp[3:0]);
    assign data_out  = dout_q;
    assign busy      = (state_q == S_WRITE);
    assign entry_cnt = cnt_q;
endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Scoreboarded bench for ram_wr_ctrl: directed key sequences followed by random words,
// checked against a nibble-queue model of the staging word and an address-indexed RAM model.

module tb_ram_wr_ctrl;
    localparam int DW = 16, AW = 8, NIB = 4;

    logic          clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
    logic          kl = 1'b1, kc = 1'b1;
    logic [3:0]    nib = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_out;
    logic          busy;
    logic [2:0]    entry_cnt;
    logic [6:0]    D1, D2, D3, D4;

    ram_wr_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .key_load_n(kl), .key_commit_n(kc),
        .nibble_in(nib), .address_in(addr), .data_out(data_out), .busy(busy),
        .entry_cnt(entry_cnt), .D1(D1), .D2(D2), .D3(D3), .D4(D4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] w; } wr_t;

    int            checks = 0, failures = 0;
    wr_t           sbq[$];
    logic [DW-1:0] ref_mem [int];
    logic [3:0]    stg[$];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100;
            4'h3: return 7'b0110000; 4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
            4'h6: return 7'b0000010; 4'h7: return 7'b1111000; 4'h8: return 7'b0000000;
            4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
            4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] disp_of(input logic [DW-1:0] w);
        return {glyph(w[15:12]), glyph(w[11:8]), glyph(w[7:4]), glyph(w[3:0])};
    endfunction

    function automatic logic [DW-1:0] stg_word();
        logic [DW-1:0] w = '0;
        foreach (stg[i]) w = (w << 4) | DW'(stg[i]);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_load(input logic [3:0] n4);
        @(negedge clk);
        nib = n4; kl = 1'b0;
        cyc(10);
        kl = 1'b1;
        cyc(10);
        if (ce) begin
            stg.push_back(n4);
            if (stg.size() > NIB) void'(stg.pop_front());
        end
        chk("load_entry_cnt", 32'(entry_cnt), 32'(stg.size()));
        if (stg.size() > 0) chk("load_disp", {D1, D2, D3, D4}, disp_of(stg_word()));
    endtask

    task automatic commit_model(input logic [AW-1:0] a);
        wr_t e;
        if (ce && stg.size() > 0) begin
            e.a = a; e.w = stg_word();
            sbq.push_back(e);
            ref_mem[int'(a)] = e.w;
            stg.delete();
        end
    endtask

    task automatic press_commit(input logic [AW-1:0] a);
        @(negedge clk);
        addr = a; kc = 1'b0;
        commit_model(a);
        cyc(10);
        kc = 1'b1;
        cyc(10);
        chk("commit_entry_cnt", 32'(entry_cnt), 32'(stg.size()));
    endtask

    // Both keys pressed together produce pulses in the same cycle.
    task automatic press_both(input logic [3:0] n4, input logic [AW-1:0] a);
        @(negedge clk);
        nib = n4; addr = a; kl = 1'b0; kc = 1'b0;
        if (stg.size() > 0) commit_model(a);
        else stg.push_back(n4);
        cyc(10);
        kl = 1'b1; kc = 1'b1;
        cyc(10);
        chk("both_entry_cnt", 32'(entry_cnt), 32'(stg.size()));
    endtask

    task automatic read_chk(input logic [AW-1:0] a);
        @(negedge clk);
        addr = a;
        cyc(2);
        chk("read_data", 32'(data_out), 32'(ref_mem[int'(a)]));
        chk("read_disp", {D1, D2, D3, D4}, disp_of(ref_mem[int'(a)]));
    endtask

    // Monitor: every WRITE must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 32'(busy), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    @(negedge clk);
                    chk("busy_one_cycle", 32'(busy), 32'd0);
                    @(negedge clk);
                    chk("wr_data", 32'(data_out), 32'(e.w));
                    chk("wr_disp", {D1, D2, D3, D4}, disp_of(e.w));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int keys[$];
        logic [AW-1:0] a;
        int nl;

        cyc(3);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_entry_cnt", 32'(entry_cnt), 32'd0);
        chk("rst_disp", {D1, D2, D3, D4}, {4{7'h40}});
        rst_n = 1'b1;
        cyc(3);

        for (int i = 1; i <= 4; i++) press_load(4'(i));
        press_commit(8'h05);
        read_chk(8'h05);

        // Bouncing load key, then a firm press.
        @(negedge clk);
        nib = 4'h9;
        for (int i = 0; i < 10; i++) begin
            kl = ~kl;
            cyc(2);
        end
        kl = 1'b0;
        cyc(10);
        kl = 1'b1;
        cyc(10);
        stg.push_back(4'h9);
        chk("bounce_entry_cnt", 32'(entry_cnt), 32'd1);
        press_commit(8'h30);

        press_load(4'hA); press_load(4'hB);
        press_commit(8'hFF);
        for (int i = 1; i <= 5; i++) press_load(4'(i));
        press_commit(8'h00);
        read_chk(8'hFF);
        read_chk(8'h00);

        press_commit(8'h07);
        press_load(4'h7); press_load(4'h8);
        press_both(4'h9, 8'h10);
        read_chk(8'h10);

        // Clock enable low: keys ignored, read port frozen.
        read_chk(8'h05);
        press_load(4'h6);
        @(negedge clk);
        ce = 1'b0;
        addr = 8'hFF;
        press_load(4'hC);
        press_commit(8'hFF);
        chk("ce0_data_out", 32'(data_out), 32'(ref_mem[5]));
        ce = 1'b1;
        press_load(4'hD);

        // Reset mid-entry.
        @(negedge clk);
        rst_n = 1'b0;
        stg.delete();
        cyc(2);
        chk("midrst_entry_cnt", 32'(entry_cnt), 32'd0);
        chk("midrst_disp", {D1, D2, D3, D4}, {4{7'h40}});
        rst_n = 1'b1;
        cyc(2);
        press_commit(8'h22);
        press_load(4'h3);
        press_commit(8'h22);
        read_chk(8'h22);

        for (int it = 0; it < 30; it++) begin
            nl = $urandom_range(0, 6);
            for (int j = 0; j < nl; j++) press_load(4'($urandom_range(0, 15)));
            a = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) press_both(4'($urandom_range(0, 15)), a);
            else press_commit(a);
        end
        if (stg.size() > 0) press_commit(8'h44);

        foreach (ref_mem[k]) keys.push_back(k);
        for (int i = 0; i < 10; i++) read_chk(AW'(keys[$urandom_range(0, keys.size() - 1)]));

        cyc(5);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
